// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder: buffers a 2-bit image and streams 3x3 windows to a conv core.
module cnn_window_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        addr_inc,
  output logic        strt,
  output logic [17:0] din,
  output logic        busy,
  output logic        done
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  typedef enum logic [2:0] {LOAD, PREP, START, FEED, FIN} state_t;
  state_t state, next;
  logic [1:0] mem [N];
  logic [AW-1:0] wr_cnt;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [17:0] win;
  logic [31:0] base;
  logic last_px, last_col, last_row, unused_bits;
  assign last_px     = wr_cnt == AW'(N - 1);
  assign last_col    = c == CW'(IMG_W - 3);
  assign last_row    = r == RW'(IMG_H - 3);
  assign unused_bits = ^rx_data[7:2];
  always_ff @(posedge clk)
    state <= rst ? LOAD : next;
  always_comb begin
    next = state;
    case (state)
      LOAD:    next = (rx_rdy && last_px) ? PREP : LOAD;
      PREP:    next = START;
      START:   next = FEED;
      FEED:    next = (addr_inc && last_col && last_row) ? FIN : FEED;
      default: next = LOAD;
    endcase
  end
  always_comb begin
    strt = state == START;
    done = state == FIN;
    busy = state != LOAD;
  end
  always_ff @(posedge clk)
    if (!rst && state == LOAD && rx_rdy) mem[wr_cnt] <= rx_data[1:0];
  // window read uses only registered r/c, so addr_inc never reaches din combinationally
  always_comb begin
    base = 32'(r) * IMG_W + 32'(c);
    win = '0;
    for (int k = 0; k < 9; k++) win[2*k +: 2] = mem[AW'(base + 32'(k / 3 * IMG_W + k % 3))];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      r      <= '0;
      c      <= '0;
      din    <= '0;
    end else begin
      if (state == LOAD && rx_rdy) wr_cnt <= last_px ? '0 : wr_cnt + 1'b1;
      if (state != FEED) begin
        r <= '0;
        c <= '0;
      end else if (addr_inc && !last_col) c <= c + 1'b1;
      else if (addr_inc && !last_row) begin
        c <= '0;
        r <= r + 1'b1;
      end
      if (state == PREP || state == FEED) din <= win;
    end
  end
endmodule

// File: doc/cnn_window_feeder.md
CNN_WINDOW_FEEDER -- requirements
Module: cnn_window_feeder

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels.
REQ-002 Parameter IMG_H, default 28, image height in pixels.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port rx_rdy  input  1  one-cycle pulse; rx_data valid this cycle.
REQ-006 Port rx_data  input  8  received pixel byte; bits [1:0] = pixel value, bits [7:2] ignored.
REQ-007 Port addr_inc  input  1  one-cycle pulse from the conv core; advance to next window.
REQ-008 Port strt  output  1  one-cycle pulse; first window valid on din, start inference.
REQ-009 Port din  output  [1:0] x 9  3x3 window; din[k] = pixel(row r+k/3, col c+k%3), k=0..8, row-major.
REQ-010 Port busy  output  1  high from PREP through DONE.
REQ-011 Port done  output  1  one-cycle pulse after the last window has been consumed.

Function
REQ-012 Storage: IMG_W*IMG_H 2-bit pixel buffer, written raster order (row 0 col 0 first).
REQ-013 States: LOAD, PREP, START, FEED, FIN; reset state LOAD.
REQ-014 LOAD: each rx_rdy writes rx_data[1:0] to buffer[wr_cnt], wr_cnt increments; rx_rdy low -> no change.
REQ-015 LOAD -> PREP on the cycle rx_rdy is accepted with wr_cnt = IMG_W*IMG_H-1; wr_cnt then clears to 0.
REQ-016 PREP (1 cycle): r=0, c=0; din registered from window (0,0); -> START.
REQ-017 START (1 cycle): strt=1, din stable at window (0,0); -> FEED.
REQ-018 FEED: addr_inc with c < IMG_W-3 -> c+1; with c = IMG_W-3 and r < IMG_H-3 -> c=0, r+1.
REQ-019 FEED: din updates exactly 1 cycle after the addr_inc edge; stable between addr_inc pulses.
REQ-020 FEED: addr_inc at r=IMG_H-3, c=IMG_W-3 -> FIN; din unchanged.
REQ-021 FIN (1 cycle): done=1; -> LOAD, ready for next image.
REQ-022 Total windows per image = (IMG_W-2)*(IMG_H-2) (676 at defaults); strt counts as the first window's presentation, addr_inc count to FIN = 676.
REQ-023 addr_inc on consecutive cycles SHALL each advance one position; none dropped.
REQ-024 addr_inc outside FEED SHALL be ignored.
REQ-025 rx_rdy outside LOAD SHALL be ignored; byte dropped, buffer unchanged.
REQ-026 busy = 1 in PREP, START, FEED, FIN; 0 in LOAD.
REQ-027 strt and done SHALL never be high simultaneously; each high exactly one cycle per image.
REQ-028 Buffer reads for din SHALL use only registered r, c; no combinational path from addr_inc to din.

Reset
REQ-029 rst high on any cycle, any state: next state LOAD, wr_cnt=0, r=0, c=0.
REQ-030 Reset values: strt=0, done=0, busy=0, din[0..8]=2'b00.
REQ-031 Buffer contents need not be cleared; a partial image in progress at reset is discarded.
REQ-032 rst has priority over rx_rdy and addr_inc in the same cycle.

Verification
REQ-033 Load 784 bytes with pixel i = i mod 4 -> strt pulses 2 cycles after last rx_rdy; din = {0,1,2,0,1,2,0,1,2} for window (0,0) (rows 0,1,2 start at pixel 0, 28, 56: 0,0,0 pattern shifted: 28 mod 4=0, 56 mod 4=0).
REQ-034 Same image, one addr_inc -> next cycle din = {1,2,3,1,2,3,1,2,3}; 25 more -> r=1, c=0, din[0]=pixel 28 = 0.
REQ-035 676 addr_inc pulses, back-to-back every cycle -> done exactly 1 cycle after the 676th, busy falls next cycle, no extra strt.
REQ-036 rx_rdy pulses during FEED with rx_data=8'hFF -> din values match unchanged buffer; addr_inc during LOAD -> no window advance after next strt (din still window (0,0)).
REQ-037 rst asserted mid-FEED at window (10,10), then new 784-byte image -> strt again, din = window (0,0) of new image, no done from aborted run.
REQ-038 Byte with rx_data=8'b1111_1110 -> stored pixel 2'b10; upper bits have no effect.
